// File: rtl/aes_pkg.sv
// Shared AES-256 datapath types and constants.
package aes_pkg;
  localparam int NB_STATE  = 16;
  localparam int NR_AES256 = 14;

  typedef logic [NB_STATE-1:0][7:0] state_t;
  typedef logic [31:0]              word_t;

  typedef enum logic [1:0] {S_KEY, S_STATE, S_OUT} addrk_st_e;
endpackage

// File: rtl/mod_addrk_stage_if.sv
// Key, state and result channels of the AddRoundKey stage.
interface mod_addrk_stage_if import aes_pkg::*; #(
  parameter int N  = NB_STATE,
  parameter int KW = N * 8 / 4
);
  logic [KW-1:0]     inp_key_word;
  logic              inp_key_valid;
  logic              outp_key_ready;
  logic [N-1:0][7:0] inp_state;
  logic              inp_state_valid;
  logic              outp_state_ready;
  logic [N-1:0][7:0] outp_state;
  logic              outp_valid;
  logic              inp_ready;
  logic [3:0]        outp_round;
  logic              outp_last;

  modport slave (
    input  inp_key_word, inp_key_valid, inp_state, inp_state_valid, inp_ready,
    output outp_key_ready, outp_state_ready, outp_state, outp_valid, outp_round, outp_last
  );

  modport master (
    output inp_key_word, inp_key_valid, inp_state, inp_state_valid, inp_ready,
    input  outp_key_ready, outp_state_ready, outp_state, outp_valid, outp_round, outp_last
  );
endinterface

// File: rtl/mod_key_asm.sv
// Round-key assembler: packs four key words into a 16-byte key, first byte from the word MSB.
module mod_key_asm import aes_pkg::*; #(
  parameter int N  = NB_STATE,
  parameter int KW = N * 8 / 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              we,
  input  logic [KW-1:0]     word,
  output logic [N-1:0][7:0] key,
  output logic              full
);
  localparam int WB = KW / 8;
  localparam int BW = $clog2(WB);
  localparam int IW = $clog2(N);

  logic [BW-1:0]      wcnt;
  logic [WB-1:0][7:0] wbytes;

  assign wbytes = word;
  assign full   = we && (wcnt == BW'(WB - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wcnt <= '0;
      key  <= '0;
    end else if (clr) begin
      wcnt <= '0;
    end else if (we) begin
      wcnt <= wcnt + BW'(1);
      for (int unsigned j = 0; j < WB; j++)
        key[IW'(WB * int'(wcnt) + int'(j))] <= wbytes[BW'(WB - 1 - int'(j))];
    end
  end
endmodule

// File: rtl/mod_addrk_stage.sv
// AddRoundKey stage: collect a round key, XOR it into the state, hand result downstream.
module mod_addrk_stage import aes_pkg::*; #(
  parameter int N  = NB_STATE,
  parameter int NR = NR_AES256,
  parameter int KW = N * 8 / 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  mod_addrk_stage_if.slave   bus
);
  localparam logic [3:0] LAST = 4'(NR);

  addrk_st_e         st, nxt;
  logic [N-1:0][7:0] key, state_q;
  logic [3:0]        rcnt, round_q;
  logic              valid_q, last_q;
  logic              key_rdy, st_rdy;
  logic              kwe, kfull, st_hs, out_hs;

  // start overrides every handshake in its cycle
  assign kwe    = key_rdy && bus.inp_key_valid && !start;
  assign st_hs  = st_rdy && bus.inp_state_valid && !start;
  assign out_hs = (st == S_OUT) && bus.inp_ready && !start;

  mod_key_asm #(.N(N), .KW(KW)) u_key_asm (
    .clk    (clk),
    .resetn (resetn),
    .clr    (start),
    .we     (kwe),
    .word   (bus.inp_key_word),
    .key    (key),
    .full   (kfull)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) st <= S_KEY;
    else         st <= nxt;
  end

  always_comb begin
    nxt     = st;
    key_rdy = 1'b0;
    st_rdy  = 1'b0;
    case (st)
      S_KEY: begin
        key_rdy = 1'b1;
        if (kfull) nxt = S_STATE;
      end
      S_STATE: begin
        st_rdy = 1'b1;
        if (st_hs) nxt = S_OUT;
      end
      S_OUT:   if (out_hs) nxt = S_KEY;
      default: nxt = S_KEY;
    endcase
    if (start) nxt = S_KEY;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= '0;
      round_q <= '0;
      rcnt    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (start) begin
      rcnt    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (st_hs) begin
        state_q <= bus.inp_state ^ key;
        round_q <= rcnt;
        last_q  <= (rcnt == LAST);
        valid_q <= 1'b1;
      end
      if (out_hs) begin
        valid_q <= 1'b0;
        rcnt    <= (rcnt == LAST) ? '0 : rcnt + 4'd1;
      end
    end
  end

  assign bus.outp_key_ready   = key_rdy;
  assign bus.outp_state_ready = st_rdy;
  assign bus.outp_state       = state_q;
  assign bus.outp_valid       = valid_q;
  assign bus.outp_round       = round_q;
  assign bus.outp_last        = last_q;
endmodule

// File: tb/tb_mod_addrk_stage.sv
// Randomised scoreboard bench for mod_addrk_stage with a byte-stream key model.
module tb_mod_addrk_stage;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;

  mod_addrk_stage_if #(.N(NB_STATE), .KW(32)) bus ();

  mod_addrk_stage #(.N(NB_STATE), .NR(NR_AES256), .KW(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    state_t     st;
    logic [3:0] rnd;
    logic       last;
  } exp_t;

  exp_t        sb[$];
  byte unsigned kbytes[$];
  int          model_r = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          rdy_rand = 1'b0;
  logic        rdy_fixed = 1'b1;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  always @(posedge clk) begin
    #2;
    bus.inp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // scoreboard monitor: one pop per downstream transfer
  always @(negedge clk) begin
    exp_t e;
    if (resetn && bus.outp_valid && bus.inp_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got round %0d, expected no output", bus.outp_round);
      end else begin
        e = sb.pop_front();
        chk("out_state", bus.outp_state, e.st);
        chk("out_round", 128'(bus.outp_round), 128'(e.rnd));
        chk("out_last", 128'(bus.outp_last), 128'(e.last));
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input bit gaps);
    int  t;
    bit  ok;
    if (gaps) begin
      bus.inp_key_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    bus.inp_key_word  = w;
    bus.inp_key_valid = 1'b1;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (bus.outp_key_ready) ok = 1'b1;
      t++;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL key_timeout: got no key_ready, expected key_ready within 200 cycles");
    end
    @(posedge clk); #1;
    bus.inp_key_valid = 1'b0;
    bus.inp_key_word  = $urandom;
    for (int j = 0; j < 4; j++) kbytes.push_back(w[31 - 8*j -: 8]);
  endtask

  task automatic send_key(input logic [31:0] w0, w1, w2, w3, input bit gaps);
    send_word(w0, gaps);
    send_word(w1, gaps);
    send_word(w2, gaps);
    send_word(w3, gaps);
  endtask

  task automatic send_state(input state_t s);
    int   t;
    bit   ok;
    exp_t e;
    bus.inp_state       = s;
    bus.inp_state_valid = 1'b1;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (bus.outp_state_ready) ok = 1'b1;
      t++;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL state_timeout: got no state_ready, expected state_ready within 200 cycles");
    end
    @(posedge clk); #1;
    bus.inp_state_valid = 1'b0;
    for (int i = 0; i < 16; i++) e.st[i] = s[i] ^ 8'(kbytes[i]);
    e.rnd  = 4'(model_r);
    e.last = (model_r == 14);
    sb.push_back(e);
    chk("latency_valid", 128'(bus.outp_valid), 128'(1));
    kbytes.delete();
    model_r = (model_r == 14) ? 0 : model_r + 1;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin @(posedge clk); #1; t++; end
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    kbytes.delete();
    model_r = 0;
  endtask

  function automatic state_t rand_state();
    state_t s;
    for (int i = 0; i < 16; i++) s[i] = 8'($urandom);
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1 ms");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    state_t s, fips_exp, snap;
    logic [31:0] w;

    bus.inp_key_word    = '0;
    bus.inp_key_valid   = 1'b0;
    bus.inp_state       = '0;
    bus.inp_state_valid = 1'b0;
    bus.inp_ready       = 1'b1;

    #3;
    chk("rst_valid", 128'(bus.outp_valid), 128'(0));
    chk("rst_round", 128'(bus.outp_round), 128'(0));
    chk("rst_last", 128'(bus.outp_last), 128'(0));
    chk("rst_state", bus.outp_state, 128'(0));
    chk("rst_key_ready", 128'(bus.outp_key_ready), 128'(1));
    chk("rst_state_ready", 128'(bus.outp_state_ready), 128'(0));
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 round 0
    send_key(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f, 1'b0);
    for (int i = 0; i < 16; i++) begin
      s[i]        = 8'(i * 17);
      fips_exp[i] = 8'(i * 16);
    end
    send_state(s);
    chk("fips_state", bus.outp_state, fips_exp);
    chk("fips_round", 128'(bus.outp_round), 128'(0));
    chk("fips_last", 128'(bus.outp_last), 128'(0));
    drain();

    // backpressure: five cycles held
    rdy_fixed = 1'b0;
    @(posedge clk); #1;
    send_key($urandom, $urandom, $urandom, $urandom, 1'b0);
    send_state(rand_state());
    snap = bus.outp_state;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 128'(bus.outp_valid), 128'(1));
      chk("bp_state", bus.outp_state, snap);
      chk("bp_key_ready", 128'(bus.outp_key_ready), 128'(0));
      chk("bp_state_ready", 128'(bus.outp_state_ready), 128'(0));
    end
    rdy_fixed = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("bp_valid_drop", 128'(bus.outp_valid), 128'(0));
    chk("bp_single_xfer", 128'(sb.size()), 128'(0));
    chk("bp_key_ready_after", 128'(bus.outp_key_ready), 128'(1));

    // full block of 15 rounds plus wrap
    pulse_start();
    rdy_rand = 1'b1;
    for (int r = 0; r < 16; r++) begin
      w = {4{8'(r % 15)}};
      send_key(w, w, w, w, 1'b0);
      send_state('0);
      chk("blk_round", 128'(bus.outp_round), 128'(r % 15));
      chk("blk_last", 128'(bus.outp_last), 128'(r == 14));
    end
    drain();

    // key words with random gaps
    for (int k = 0; k < 3; k++) begin
      send_key($urandom, $urandom, $urandom, $urandom, 1'b1);
      @(negedge clk);
      chk("gap_key_ready", 128'(bus.outp_key_ready), 128'(0));
      chk("gap_state_ready", 128'(bus.outp_state_ready), 128'(1));
      @(posedge clk); #1;
      send_state(rand_state());
    end
    drain();

    // start while a key word is offered mid-key
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    bus.inp_key_word  = 32'hdeadbeef;
    bus.inp_key_valid = 1'b1;
    pulse_start();
    bus.inp_key_valid = 1'b0;
    chk("start_key_ready", 128'(bus.outp_key_ready), 128'(1));
    send_key($urandom, $urandom, $urandom, $urandom, 1'b0);
    send_state(rand_state());
    chk("start_round", 128'(bus.outp_round), 128'(0));
    drain();

    // random traffic
    for (int k = 0; k < 12; k++) begin
      send_key($urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
      send_state(rand_state());
    end
    drain();

    // async reset while holding an output
    rdy_rand  = 1'b0;
    rdy_fixed = 1'b0;
    @(posedge clk); #1;
    send_key($urandom, $urandom, $urandom, $urandom, 1'b0);
    send_state(rand_state());
    @(negedge clk);
    chk("pre_rst_valid", 128'(bus.outp_valid), 128'(1));
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", 128'(bus.outp_valid), 128'(0));
    chk("arst_state", bus.outp_state, 128'(0));
    chk("arst_round", 128'(bus.outp_round), 128'(0));
    sb.delete();
    kbytes.delete();
    model_r = 0;
    @(negedge clk); resetn = 1'b1;
    rdy_fixed = 1'b1;
    @(posedge clk); #1;
    chk("arst_key_ready", 128'(bus.outp_key_ready), 128'(1));
    send_key($urandom, $urandom, $urandom, $urandom, 1'b0);
    send_state(rand_state());
    chk("arst_round_after", 128'(bus.outp_round), 128'(0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mod_addrk_stage.md
Name: mod_addrk_stage

Overview:
- AddRoundKey stage of the AES-256 datapath. It sits directly downstream of the 16-byte round state register.
- Assembles each 128-bit round key from four 32-bit words supplied by key expansion, XORs it with the registered state, and presents the result to the next round's SubBytes under a valid/ready handshake.
- Tracks the round index 0..14 and flags the final round.

Parameters:
- N, 16, number of state bytes.
- NR, 14, index of the last round (AES-256).
- KW, 32, key-word width in bits; fixed as N*8/4.

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  synchronous pulse: begin a new block at round 0.
- inp_key_word  input  KW  round-key word.
- inp_key_valid  input  1  inp_key_word valid.
- outp_key_ready  output  1  stage accepts a key word.
- inp_state  input  [N-1:0][7:0]  state from the round state register.
- inp_state_valid  input  1  inp_state valid.
- outp_state_ready  output  1  stage accepts the state.
- outp_state  output  [N-1:0][7:0]  state XOR round key.
- outp_valid  output  1  outp_state valid.
- inp_ready  input  1  downstream accepts outp_state.
- outp_round  output  4  round index of outp_state.
- outp_last  output  1  outp_state belongs to round NR.

Behaviour:
- Reset (resetn low, asynchronous): FSM to S_KEY; key buffer, word counter, round counter, outp_state cleared to 0; outp_valid=0; outp_last=0; outp_round=0.
- Reset mid-operation discards any partial key and any held output.
- FSM states:
  - S_KEY: outp_key_ready=1. Each cycle with inp_key_valid=1 stores the word at index wcnt (0..3). Word k maps to bytes 4k..4k+3, with inp_key_word[31:24] going to byte 4k. wcnt increments. Accepting word 3 sets wcnt to 0 and moves to S_STATE.
  - S_STATE: outp_state_ready=1. With inp_state_valid=1: outp_state[i] = inp_state[i] ^ key[i] for all i, registered; outp_round = rcnt; outp_last = (rcnt==NR); outp_valid=1; go to S_OUT. Latency is 1 cycle from state handshake to outp_valid.
  - S_OUT: outp_state, outp_round and outp_last are held stable while inp_ready=0. On inp_ready=1: outp_valid=0. If rcnt==NR then rcnt=0, otherwise rcnt=rcnt+1. Go to S_KEY.
- outp_key_ready is 0 outside S_KEY; key words offered then are not consumed.
- outp_state_ready is 0 outside S_STATE.
- Round wrap: after round NR is accepted downstream, the counter wraps to 0 and the next block proceeds without needing start.
- start has priority over all handshakes in the same cycle. It sets FSM to S_KEY, wcnt=0, rcnt=0, outp_valid=0, and clears outp_last. Handshakes coincident with start are discarded.
- outp_state is not cleared when outp_valid drops; it holds its last value.
- Valid/ready rule: a transfer occurs only when valid and ready are both 1 on a rising clk edge. Valid, once raised by this block, does not drop without a transfer, except on start or reset.

Decomposition:
- Shared package aes_pkg holds: NB_STATE=16, NR_AES256=14, typedef state_t = logic [15:0][7:0], typedef word_t = logic [31:0], and the FSM enum addrk_st_e {S_KEY, S_STATE, S_OUT}.
- The key-word assembler (wcnt plus 4-word buffer, with full/clear outputs) is a natural sub-module: mod_key_asm.
- The XOR remains inline.

Test Plan:
- Round 0, FIPS-197 vector: key words 00010203, 04050607, 08090a0b, 0c0d0e0f; state 00112233445566778899aabbccddeeff. Expect outp_state = 00102030405060708090a0b0c0d0e0f0, outp_round=0, outp_last=0, outp_valid one cycle after the state handshake.
- Backpressure: hold inp_ready=0 for 5 cycles. Expect outp_state and outp_valid stable, outp_key_ready=0 and outp_state_ready=0 throughout. On release, the transfer occurs once.
- Full block: 15 key/state pairs with the state all-zero and key bytes all set to the round number. Expect outp_state bytes = round number and outp_last=1 only on round 14. A 16th pair reports round 0 (wrap).
- Key gaps: toggle inp_key_valid on and off randomly during the 4 words. Expect the correct byte placement and exactly 4 words consumed.
- start mid-key: after 2 words, pulse start while offering a word. Expect that word discarded, wcnt=0, and the next 4 words forming the key at round 0.
- Async reset while in S_OUT with outp_valid=1. Expect outp_valid=0, outp_state=0, outp_round=0 immediately, and outp_key_ready=1 after reset releases.
